// File: rtl/zap_wb_mem_responder.sv
// zap_wb_mem_responder: Wishbone B3 responder backed by an on-chip word memory.
// Handles classic cycles and incrementing bursts. Ack, err and read data are
// registered. Burst beats are zero-wait because the next beat's ack or err is
// set up in advance whenever the master keeps strobing.
//
// Handshake: a beat completes on the rising edge where i_wb_cyc, i_wb_stb and
// one of o_wb_ack or o_wb_err are all high. Ack or err shown while stb is low
// during a burst stall is not qualified, so it completes no beat and causes no
// write.
`timescale 1ns/1ps
module zap_wb_mem_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int FIRST_LAT   = 2
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_wen,
    input  logic [3:0]  i_wb_sel,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [2:0]  i_wb_cti,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    output logic [1:0]  o_dbg_state
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_LOAD = 4'(FIRST_LAT - 1);
    localparam logic [2:0] CTI_INC  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LAT   = 2'd1,
        S_ACK   = 2'd2,
        S_BURST = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic [3:0]  lat_q, lat_d;
    logic        ack_d, err_d;
    logic [29:0] rd_addr;
    logic [29:0] addr_plus;
    logic        beat;
    logic        mem_we;
    logic [AW-1:0] wr_idx, rd_idx;
    logic [31:0] rd_word;
    logic        unused_bits;

    logic [31:0] mem [DEPTH_WORDS];

    // Word addresses with any bit at or above AW set lie outside the memory.
    function automatic logic in_range(input logic [29:0] a);
        return (a[29:AW] == '0);
    endfunction

    assign addr_plus   = addr_q + 30'd1;
    assign beat        = ((state_q == S_ACK) || (state_q == S_BURST)) &&
                         i_wb_cyc && i_wb_stb && (o_wb_ack || o_wb_err);
    assign mem_we      = beat && o_wb_ack && i_wb_wen;
    assign wr_idx      = addr_q[AW-1:0];
    assign o_dbg_state = state_q;
    assign unused_bits = ^{i_wb_adr[1:0], rd_addr[29:AW]};

    // Next-state, next ack/err and the word address to prefetch for next cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lat_d   = lat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rd_addr = addr_q;
        case (state_q)
            S_IDLE: begin
                if (i_wb_cyc && i_wb_stb) begin
                    addr_d  = i_wb_adr[31:2];
                    rd_addr = i_wb_adr[31:2];
                    if (i_wb_wen && (FIRST_LAT == 1)) begin
                        state_d = S_ACK;
                        ack_d   = in_range(i_wb_adr[31:2]);
                        err_d   = !in_range(i_wb_adr[31:2]);
                    end else begin
                        state_d = S_LAT;
                        lat_d   = LAT_LOAD;
                    end
                end
            end
            S_LAT: begin
                if (!i_wb_cyc) begin
                    state_d = S_IDLE;
                    lat_d   = '0;
                end else if (lat_q == '0) begin
                    state_d = S_ACK;
                    ack_d   = in_range(addr_q);
                    err_d   = !in_range(addr_q);
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            S_ACK, S_BURST: begin
                if (!i_wb_cyc) begin
                    state_d = S_IDLE;
                end else if (beat) begin
                    if (o_wb_err || (i_wb_cti != CTI_INC)) begin
                        state_d = S_IDLE;
                    end else begin
                        // Beat done and more to come: step and present the next beat now.
                        state_d = S_BURST;
                        addr_d  = addr_plus;
                        rd_addr = addr_plus;
                        ack_d   = in_range(addr_plus);
                        err_d   = !in_range(addr_plus);
                    end
                end else if ((state_q == S_BURST) && i_wb_stb) begin
                    // Master resumes after a stall: answer the held address.
                    ack_d = in_range(addr_q);
                    err_d = !in_range(addr_q);
                end else if (state_q == S_ACK) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Memory read port with bypass of a same-edge write to the same word.
    always_comb begin
        rd_idx  = rd_addr[AW-1:0];
        rd_word = mem[rd_idx];
        for (int b = 0; b < 4; b++) begin
            if (mem_we && (wr_idx == rd_idx) && i_wb_sel[b]) begin
                rd_word[8*b +: 8] = i_wb_dat[8*b +: 8];
            end
        end
    end

    // Control state and registered bus outputs; async clear.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            lat_q    <= '0;
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            o_wb_dat <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            lat_q    <= lat_d;
            o_wb_ack <= ack_d;
            o_wb_err <= err_d;
            o_wb_dat <= rd_word;
        end
    end

    // Byte-enabled write of a completed write beat; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wb_sel[b]) begin
                    mem[wr_idx][8*b +: 8] <= i_wb_dat[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_zap_wb_mem_responder.sv
// Bench for zap_wb_mem_responder: a Wishbone master driver, a word-level
// memory model and one scoreboard process checking every qualified response.
`timescale 1ns/1ps
module tb_zap_wb_mem_responder;

    localparam int DEPTH     = 4096;
    localparam int FIRST_LAT = 2;

    // ---------------- clock / reset / DUT ----------------
    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_wb_cyc, i_wb_stb, i_wb_wen;
    logic [3:0]  i_wb_sel;
    logic [31:0] i_wb_adr, i_wb_dat;
    logic [2:0]  i_wb_cti;
    logic [31:0] o_wb_dat;
    logic        o_wb_ack, o_wb_err;
    logic [1:0]  dbg_state;

    always #5 i_clk = ~i_clk;

    zap_wb_mem_responder #(.DEPTH_WORDS(DEPTH), .FIRST_LAT(FIRST_LAT)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_wen(i_wb_wen),
        .i_wb_sel(i_wb_sel), .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat),
        .i_wb_cti(i_wb_cti), .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack),
        .o_wb_err(o_wb_err), .o_dbg_state(dbg_state)
    );

    // ---------------- model and scoreboard state ----------------
    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] model_mem [DEPTH];
    bit          model_vld [DEPTH];
    // {is_err, check_data, data}
    logic [33:0] exp_q[$];
    logic [31:0] bdat [16];
    logic [3:0]  bsel [16];
    logic [31:0] rdata_log [16];
    int          n_resp, n_err;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [33:0] expect_for(input bit wen, input logic [29:0] wd);
        int idx;
        if (wd >= 30'(DEPTH)) return {1'b1, 1'b0, 32'h0};
        if (wen) return {2'b00, 32'h0};
        idx = int'(wd);
        return {1'b0, model_vld[idx], model_mem[idx]};
    endfunction

    task automatic model_write(input logic [29:0] wd, input logic [31:0] dat, input logic [3:0] sel);
        int idx;
        idx = int'(wd);
        for (int b = 0; b < 4; b++)
            if (sel[b]) model_mem[idx][8*b +: 8] = dat[8*b +: 8];
        if (sel == 4'hF) model_vld[idx] = 1'b1;
    endtask

    // Scoreboard: every qualified ack/err is matched against the next expectation.
    always @(negedge i_clk) begin
        if (i_reset_n && i_wb_cyc && i_wb_stb && (o_wb_ack || o_wb_err)) begin
            logic [33:0] e;
            chk("ack_err_exclusive", {31'd0, o_wb_ack & o_wb_err}, 32'd0);
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_resp: got ack=%0b err=%0b expected none", o_wb_ack, o_wb_err);
            end else begin
                e = exp_q.pop_front();
                chk("resp_is_err", {31'd0, o_wb_err}, {31'd0, e[33]});
                if (!e[33] && e[32]) chk("read_data", o_wb_dat, e[31:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_wen = 1'b0;
        i_wb_sel = 4'h0; i_wb_adr = 32'h0; i_wb_dat = 32'h0; i_wb_cti = 3'b000;
    endtask

    task automatic present(input bit wen, input logic [29:0] wd, input int i, input int n, input bit classic);
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        i_wb_wen = wen;
        i_wb_adr = {wd, 2'b00};
        i_wb_dat = bdat[i];
        i_wb_sel = bsel[i];
        i_wb_cti = classic ? 3'b000 : ((i == n - 1) ? 3'b111 : 3'b010);
        exp_q.push_back(expect_for(wen, wd));
    endtask

    // One classic cycle (n=1, classic=1) or an incrementing burst of n beats.
    // stall_after=k drops stb for gap cycles after beat k; abort_after=k resets after beat k.
    task automatic run_xfer(input bit wen, input logic [31:0] adr, input int n, input bit classic,
                            input int stall_after, input int gap, input int abort_after);
        logic [29:0] w0;
        logic [31:0] rd;
        int i, t, first_t, last_t, exp_lat;
        bit resp, rerr, done;
        w0 = adr[31:2];
        i = 0; t = 0; first_t = -1; last_t = -1; done = 0;
        n_resp = 0; n_err = 0;
        @(posedge i_clk); #1;
        present(wen, w0, 0, n, classic);
        while (!done && t < 200) begin
            @(negedge i_clk);
            resp = i_wb_stb && (o_wb_ack || o_wb_err);
            rerr = o_wb_err;
            rd   = o_wb_dat;
            @(posedge i_clk);
            t++;
            if (resp) begin
                if (i < 16) rdata_log[i] = rd;
                n_resp++;
                if (rerr) n_err++;
                if (!rerr && wen) model_write(w0 + 30'(i), i_wb_dat, i_wb_sel);
                if (first_t < 0) first_t = t;
                last_t = t;
                i++;
                if (abort_after == i) begin
                    #2 i_reset_n = 1'b0;
                    #1;
                    chk("async_rst_ack", {31'd0, o_wb_ack}, 32'd0);
                    chk("async_rst_err", {31'd0, o_wb_err}, 32'd0);
                    chk("async_rst_dat", o_wb_dat, 32'd0);
                    drive_idle();
                    exp_q.delete();
                    repeat (2) @(posedge i_clk);
                    #1 i_reset_n = 1'b1;
                    return;
                end
                if (rerr || i == n) begin
                    done = 1;
                end else begin
                    if (stall_after == i) begin
                        #1 i_wb_stb = 1'b0;
                        repeat (gap) @(posedge i_clk);
                    end
                    #1 present(wen, w0 + 30'(i), i, n, classic);
                end
            end
        end
        chk("xfer_completed", {31'd0, done}, 32'd1);
        #1 drive_idle();
        exp_lat = (wen && FIRST_LAT == 1) ? 2 : FIRST_LAT + 2;
        chk("first_latency", first_t, exp_lat);
        if (!classic && n > 1 && stall_after == 0)
            chk("zero_wait_beats", last_t - first_t, n_resp - 1);
        @(negedge i_clk);
        chk("idle_after_end", {30'd0, o_wb_ack, o_wb_err}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            model_mem[k] = 32'h0;
            model_vld[k] = 1'b0;
        end
        drive_idle();
        i_reset_n = 1'b0;
        #1;
        chk("rst_ack", {31'd0, o_wb_ack}, 32'd0);
        chk("rst_err", {31'd0, o_wb_err}, 32'd0);
        repeat (3) @(posedge i_clk);
        #1 i_reset_n = 1'b1;
        @(negedge i_clk);
        chk("post_rst_ack", {31'd0, o_wb_ack}, 32'd0);
        chk("post_rst_dat", o_wb_dat, 32'd0);

        // Classic write then read back.
        bdat[0] = 32'hDEADBEEF; bsel[0] = 4'hF;
        run_xfer(1'b1, 32'h10, 1, 1'b1, 0, 0, 0);
        run_xfer(1'b0, 32'h10, 1, 1'b1, 0, 0, 0);
        chk("classic_read", rdata_log[0], 32'hDEADBEEF);

        // Byte write into the same word.
        bdat[0] = 32'h0000AB00; bsel[0] = 4'b0010;
        run_xfer(1'b1, 32'h10, 1, 1'b1, 0, 0, 0);
        chk("model_pin_byte", model_mem[4], 32'hDEADABEF);
        run_xfer(1'b0, 32'h10, 1, 1'b1, 0, 0, 0);
        chk("byte_write_read", rdata_log[0], 32'hDEADABEF);

        // Preload 1..4 at 0x100 and read them back as a zero-wait burst.
        for (int k = 0; k < 4; k++) begin bdat[k] = 32'(k + 1); bsel[k] = 4'hF; end
        run_xfer(1'b1, 32'h100, 4, 1'b0, 0, 0, 0);
        run_xfer(1'b0, 32'h100, 4, 1'b0, 0, 0, 0);
        for (int k = 0; k < 4; k++) chk("burst_read_lit", rdata_log[k], 32'(k + 1));
        chk("burst_resp_count", n_resp, 4);

        // Same burst with a two-cycle master stall after beat 1.
        run_xfer(1'b0, 32'h100, 4, 1'b0, 1, 2, 0);
        chk("stall_beat2", rdata_log[1], 32'd2);
        chk("stall_beat4", rdata_log[3], 32'd4);
        chk("stall_resp_count", n_resp, 4);

        // Out-of-range classic read.
        run_xfer(1'b0, DEPTH * 4, 1, 1'b1, 0, 0, 0);
        chk("oor_err_count", n_err, 1);
        chk("oor_resp_count", n_resp, 1);

        // Burst crossing the top word: two acks then err, then end.
        bdat[0] = 32'h11112222; bdat[1] = 32'h33334444; bsel[0] = 4'hF; bsel[1] = 4'hF;
        run_xfer(1'b1, (DEPTH - 2) * 4, 2, 1'b0, 0, 0, 0);
        run_xfer(1'b0, (DEPTH - 2) * 4, 4, 1'b0, 0, 0, 0);
        chk("cross_resp_count", n_resp, 3);
        chk("cross_err_count", n_err, 1);
        chk("cross_last_word", rdata_log[1], 32'h33334444);
        run_xfer(1'b1, (DEPTH - 1) * 4, 3, 1'b0, 0, 0, 0);
        chk("cross_wr_resp_count", n_resp, 2);

        // Reset in the middle of a write burst.
        for (int k = 0; k < 5; k++) begin bdat[k] = 32'hA000_0000 + 32'(k); bsel[k] = 4'hF; end
        run_xfer(1'b1, 32'h200, 5, 1'b0, 0, 0, 0);
        for (int k = 0; k < 5; k++) bdat[k] = 32'hB000_0000 + 32'(k);
        run_xfer(1'b1, 32'h200, 5, 1'b0, 0, 0, 2);
        run_xfer(1'b0, 32'h200, 5, 1'b0, 0, 0, 0);
        chk("abort_beat2_written", rdata_log[1], 32'hB000_0001);
        chk("abort_beat3_kept", rdata_log[2], 32'hA000_0002);
        chk("abort_beat5_kept", rdata_log[4], 32'hA000_0004);

        // Randomised traffic over a preloaded 64-word window at 0x1000.
        for (int blk = 0; blk < 4; blk++) begin
            for (int k = 0; k < 16; k++) begin bdat[k] = $urandom; bsel[k] = 4'hF; end
            run_xfer(1'b1, 32'h1000 + 32'(blk * 64), 16, 1'b0, 0, 0, 0);
        end
        for (int it = 0; it < 40; it++) begin
            bit r_wen, r_classic;
            int r_n, r_start, r_stall, r_gap;
            r_wen     = 1'($urandom_range(0, 1));
            r_classic = ($urandom_range(0, 2) == 0);
            r_n       = r_classic ? 1 : $urandom_range(1, 8);
            r_start   = $urandom_range(0, 64 - r_n);
            r_stall   = (r_n > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, r_n - 1) : 0;
            r_gap     = $urandom_range(1, 3);
            for (int k = 0; k < 16; k++) begin
                bdat[k] = $urandom;
                bsel[k] = 4'($urandom_range(0, 15));
            end
            run_xfer(r_wen, 32'h1000 + 32'(r_start * 4), r_n, r_classic, r_stall, r_gap, 0);
            chk("rand_resp_count", n_resp, r_n);
        end

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global time bound in case the driver itself stalls.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
